// File: rtl/seven_seg_capture.sv
// Receiver for a scanned, active-low 7-segment display bus: debounces each digit,
// decodes its glyph back to hex and presents whole frames on a valid/ready handshake.
module seven_seg_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [6:0]            Seg,
    input  logic [DIGITS-1:0]     An,
    input  logic                  FrameReady,
    input  logic                  ErrClr,
    output logic [4*DIGITS-1:0]   Value,
    output logic                  FrameValid,
    output logic                  Error,
    output logic                  Overrun
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  STABLE   = CNT_W'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= STABLE)
            return STABLE;
        return c + 1'b1;
    endfunction

    // Returns {recognised, nibble}; segment order is a..g from MSB to LSB, active-low.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    logic [6:0]          seg_p0, seg_p1;
    logic [DIGITS-1:0]   an_p0, an_p1;
    logic [CNT_W-1:0]    dwell_cnt;
    logic                captured;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] shadow;

    logic                vld_p0, multi_p0, changed_p0;
    logic                capture_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic [DIGITS-1:0]   cap_mask_p1;
    logic [4:0]          glyph_p1;
    logic                seen_full, accept, err_set, ovr_set;

    // Stage p0: registered pins; stage p1: the previous sample, kept for comparison.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            seg_p0 <= '1;
            an_p0  <= '1;
            seg_p1 <= '1;
            an_p1  <= '1;
        end else begin
            seg_p0 <= Seg;
            an_p0  <= An;
            seg_p1 <= seg_p0;
            an_p1  <= an_p0;
        end
    end

    always_comb begin
        vld_p0     = ($countones(~an_p0) == 1);
        multi_p0   = ($countones(~an_p0) > 1);
        changed_p0 = (seg_p0 != seg_p1) || (an_p0 != an_p1);
    end

    // Once the dwell counter sits at STABLE, p1 always holds the digit that dwelt,
    // even if the pins have already moved on, so the capture reads from p1.
    always_comb begin
        capture_p1  = (dwell_cnt == STABLE) && !captured;
        idx_p1      = '0;
        cap_mask_p1 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_p1[i])
                idx_p1 = IDX_W'(i);
        end
        cap_mask_p1[idx_p1] = capture_p1;
        glyph_p1    = decode_glyph(seg_p1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dwell_cnt <= '0;
            captured  <= 1'b0;
        end else if (changed_p0) begin
            dwell_cnt <= vld_p0 ? CNT_W'(1) : '0;
            captured  <= 1'b0;
        end else begin
            dwell_cnt <= vld_p0 ? sat_inc(dwell_cnt) : '0;
            if (capture_p1)
                captured <= 1'b1;
        end
    end

    always_comb begin
        seen_full = (seen == ALL_SEEN);
        accept    = FrameValid && FrameReady;
        err_set   = multi_p0 || (capture_p1 && !glyph_p1[4]);
        ovr_set   = seen_full && FrameValid && !accept;
    end

    // Stage p2: shadow word assembly and frame hand-off.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            seen <= '0;
        else
            seen <= (seen_full ? '0 : seen) | cap_mask_p1;
    end

    always_ff @(posedge Clk) begin
        if (capture_p1)
            shadow[{idx_p1, 2'b00} +: 4] <= glyph_p1[3:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Value      <= '0;
            FrameValid <= 1'b0;
        end else if (seen_full) begin
            if (!FrameValid || accept) begin
                Value      <= shadow;
                FrameValid <= 1'b1;
            end
        end else if (accept) begin
            FrameValid <= 1'b0;
        end
    end

    // Set events win over a simultaneous clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Error   <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            Error   <= err_set || (Error && !ErrClr);
            Overrun <= ovr_set || (Overrun && !ErrClr);
        end
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receiving end of the processor's multiplexed 7-segment display bus (active-low segments, active-low digit enables).
- Watches the scanned segment and enable lines, decodes each digit glyph back to a hex nibble, and rebuilds the displayed word.
- Presents each complete frame on a valid/ready handshake.
- Used for board loopback and for self-checking simulation of the top-level display output.

Parameters:
- DIGITS, 8, number of scanned digits; width of the An input; Value is 4*DIGITS bits.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (1..255).
- CNT_W, 8, width of the dwell counter; must hold STABLE_CYCLES.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Seg  in  7  segment lines, active-low; Seg[6]=a ... Seg[0]=g.
- An  in  DIGITS  digit enables, active-low; An[0] is the rightmost digit and maps to Value[3:0].
- FrameReady  in  1  consumer accepts the frame when high while FrameValid is high.
- ErrClr  in  1  synchronous clear of Error and Overrun.
- Value  out  4*DIGITS  last completed frame; stable while FrameValid is high.
- FrameValid  out  1  a complete frame is waiting in Value.
- Error  out  1  sticky: an unrecognised glyph or multiple-enable sample was seen.
- Overrun  out  1  sticky: a frame completed while the previous frame was still unaccepted.

Behaviour:
- Reset (Reset=0, async) values:
  - Value=0, FrameValid=0, Error=0, Overrun=0.
  - Dwell counter=0, seen mask=0, captured flag=0, sample registers=all ones.
- Sampling: Seg and An are registered once (sample stage), and also held one cycle further for comparison.
- Dwell: a sample is valid when An has exactly one bit low.
  - Valid sample equal to the previous sample (same Seg and same An): the counter increments, saturating at STABLE_CYCLES.
  - Any change in Seg or An: counter=1 if the new sample is valid, else 0; captured flag clears.
  - An all ones (blanking): counter=0, no capture, no error.
  - An with two or more bits low: counter=0, Error set.
- Capture: occurs on the cycle the counter reaches STABLE_CYCLES with the captured flag clear.
  - The decoded nibble is written into the shadow word at digit index i, where i is the low bit of An.
  - seen[i] is set and the captured flag is set.
  - Exactly one capture per dwell, however long the dwell lasts.
  - Latency: the capture is visible in the shadow STABLE_CYCLES+1 cycles after the first edge of a new digit on the pins.
- Decode table (pattern a..g, active-low, to hex): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
  - Any other pattern stores nibble 0, sets seen[i], and sets Error.
- Frame completion: on the cycle after seen becomes all ones, seen clears to 0.
  - If FrameValid=0: Value<=shadow and FrameValid<=1.
  - If FrameValid=1 and it is not accepted that cycle: the new frame is dropped, Value is unchanged, Overrun is set.
  - If FrameValid=1 and it is accepted that same cycle: Value<=shadow and FrameValid stays 1 (back-to-back, no loss).
- Handshake: FrameValid&FrameReady accepts; FrameValid clears the next cycle unless a new frame loads simultaneously. Value must not change while FrameValid=1 and not accepted.
- A repeat of an already-seen digit before the frame completes overwrites that nibble; seen is unchanged.
- ErrClr=1 clears Error and Overrun; a set event in the same cycle wins (the flag stays 1).
- Reset mid-dwell or mid-frame discards the partial shadow and seen mask; no frame is emitted.

Test Plan:
- Scan 0x1234ABCD, digits 0..7, 6 cycles per digit, FrameReady=1 -> one FrameValid pulse with Value=32'h1234ABCD, Error=0.
- Dwell digit 3 showing 7 for 40 cycles inside a scan -> seen[3] set once; Value nibble[15:12]=7; exactly one frame per full scan.
- Digit 2 held for only 3 cycles (STABLE_CYCLES=4), then the scan continues -> no frame until digit 2 is revisited for 4 or more cycles.
- Digit 5 pattern 1111111, then An=8'b11100111 -> Error=1, nibble[23:20]=0; ErrClr pulse -> Error=0.
- FrameReady=0 across two full scans of 0xDEADBEEF then 0x00000001 -> Value stays 32'hDEADBEEF, Overrun=1; FrameReady=1 -> FrameValid drops next cycle.
- Assert Reset after 4 of 8 digits, release, scan 0xFFFFFFFF -> single frame Value=32'hFFFFFFFF; no stale digits from before reset.
